riscv_cu_alu_ctrl: RTL and testbench
====================================

// Module: riscv_cu_alu_ctrl
// PURPOSE
//  Decode-stage producer for the datapath ALU: turns a 32-bit RV32I instruction into ALU
//  control (ctrl), immediate and operand-B select, registered behind a valid/ready skid buffer.
//  Sits between fetch and the datapath ALU stage; backpressure from execute never drops or duplicates instructions.
// PARAMETERS
//  MP_DATA_WIDTH  32  datapath/immediate width (only 32 supported)
// PORTS
//  iclk         in   1   clock; all state on rising edge
//  irst_n       in   1   asynchronous active-low reset
//  ivalid       in   1   upstream instruction valid
//  oready       out  1   block can accept an instruction this cycle
//  iinstr       in   32  RV32I instruction word
//  ovalid       out  1   decoded entry valid toward execute
//  iready       in   1   execute stage accepts entry
//  octrl        out  4   ALU op code (RISCV_ALU_*_OP)
//  osrc_b_imm   out  1   1: ALU operand B = oimm, 0: = rs2
//  oimm         out  32  sign-extended immediate
//  oillegal     out  1   illegal encoding (see CONFIGURATION)
// BEHAVIOUR
//  Op codes (fixed): ADD 0000 SUB 0001 AND 0010 OR 0011 XOR 0100 SLT 0101 SLTU 1001
//   SL 0110 SR 0111 SRA 1010. Bit0=1 => ALU subtracts; bit1=0 => carry/ovf valid (SLT/SLTU rely on it).
//  Decode (opcode iinstr[6:0]):
//   0110011 R: f3 000 ADD/SUB(f7[5]), 001 SL, 010 SLT, 011 SLTU, 100 XOR, 101 SR/SRA(f7[5]), 110 OR, 111 AND; osrc_b_imm=0
//   0010011 I: as R but f3 000 always ADD; f3 101 uses f7[5]; osrc_b_imm=1, I-imm
//   0000011 load / 1100111 jalr: ADD, I-imm, imm sel 1; 0100011 store: ADD, S-imm, imm sel 1
//   1100011 branch: f3 00x SUB, 10x SLT, 11x SLTU; B-imm; osrc_b_imm=0
//   0110111 lui / 0010111 auipc: ADD, U-imm (instr[31:12]<<12), imm sel 1; 1101111 jal: ADD, J-imm, imm sel 1
//   immediates sign-extend from iinstr[31]; B/J imm bit0 = 0
//  Handshake: transfer in when ivalid&oready; out when ovalid&iready. Payload stable while ovalid&~iready.
//  Skid buffer: main reg (drives outputs) + one skid reg. oready = ~skid_valid (registered, no comb path from iready).
//   - accept, main empty or draining: load main directly
//   - accept, main held (~iready): load skid; oready drops next cycle
//   - main drains with skid valid: main <= skid, skid clears, oready rises next cycle
//   - simultaneous accept+drain, skid empty: main replaced same edge
//  Latency: 1 cycle ivalid&oready -> ovalid. Throughput 1/cycle with iready held high.
//  Reset (async, any time incl. mid-transfer): ovalid=0, skid_valid=0, oready=1 after release,
//   octrl=ADD(0000), osrc_b_imm=0, oimm=0, oillegal=0; in-flight entries discarded.
// CONFIGURATION
//  RISCV_ALU_CTRL_ILLEGAL_EN defined: unknown opcode, R-type f7 not in {0000000,0100000}
//   (0100000 only with f3 000/101), I-type shift f7 not in same set, branch f3 01x, load f3 011/110/111,
//   store f3 >= 011 => oillegal=1, octrl=ADD, osrc_b_imm=0, oimm=0; entry still flows via handshake.
//  Not defined: oillegal tied 0; unknown opcode decodes as ADD, osrc_b_imm=0, oimm=0; bad f7 ignores all but bit 5.
// STRUCTURE
//  riscv_constants.vh: RISCV_ALU_*_OP codes, RISCV_OPC_* 7-bit opcode constants, RISCV_IMM_* selectors (I,S,B,U,J).
//  Sub-module riscv_cu_imm_gen: combinational iinstr + imm sel -> oimm. Decode comb logic and skid buffer stay in top.
// TESTING
//  1 add x3,x1,x2 (0x002081B3), iready=1 -> next cycle ovalid=1, octrl=0000, osrc_b_imm=0
//  2 sub (0x402081B3) then srai x1,x1,3 (0x4030D093) -> octrl 0001, then 1010, osrc_b_imm=1, oimm=3
//  3 blt (f3 100), bltu (f3 110), beq -> octrl 0101, 1001, 0001; beq offset -4 -> oimm=0xFFFFFFFC
//  4 iready=0 for 3 cycles while 2 instrs sent -> oready=0 after 2nd, 1st held stable; iready=1 -> both out in order, none lost
//  5 irst_n low mid-stall with main+skid full -> ovalid=0, octrl=0000 immediately; oready=1 after release
//  6 opcode 0x7F: with RISCV_ALU_CTRL_ILLEGAL_EN oillegal=1, octrl=0000; without, oillegal=0, octrl=0000

Source files
------------

// File: rtl/riscv_cu_alu_ctrl_pkg.sv
// Shared constants and types for the RV32I ALU-control decode stage:
// ALU op codes, major opcodes, immediate selectors and the decoded entry.
// Optional feature macro used by the top: RISCV_ALU_CTRL_ILLEGAL_EN.
package riscv_cu_alu_ctrl_pkg;

  // ALU op codes. Bit0 set means the ALU subtracts; bit1 clear means the
  // carry/overflow outputs are meaningful, which SLT/SLTU depend on.
  localparam logic [3:0] RISCV_ALU_ADD_OP  = 4'b0000;
  localparam logic [3:0] RISCV_ALU_SUB_OP  = 4'b0001;
  localparam logic [3:0] RISCV_ALU_AND_OP  = 4'b0010;
  localparam logic [3:0] RISCV_ALU_OR_OP   = 4'b0011;
  localparam logic [3:0] RISCV_ALU_XOR_OP  = 4'b0100;
  localparam logic [3:0] RISCV_ALU_SLT_OP  = 4'b0101;
  localparam logic [3:0] RISCV_ALU_SLTU_OP = 4'b1001;
  localparam logic [3:0] RISCV_ALU_SL_OP   = 4'b0110;
  localparam logic [3:0] RISCV_ALU_SR_OP   = 4'b0111;
  localparam logic [3:0] RISCV_ALU_SRA_OP  = 4'b1010;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] RISCV_OPC_OP     = 7'b0110011;
  localparam logic [6:0] RISCV_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] RISCV_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] RISCV_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] RISCV_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] RISCV_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] RISCV_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] RISCV_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] RISCV_OPC_JAL    = 7'b1101111;

  // Immediate format selector. SH is the 5-bit shift amount of I-type
  // shifts, so the ALU sees a clean shamt rather than the funct7 bits.
  typedef enum logic [2:0] {
    RISCV_IMM_NONE,
    RISCV_IMM_I,
    RISCV_IMM_S,
    RISCV_IMM_B,
    RISCV_IMM_U,
    RISCV_IMM_J,
    RISCV_IMM_SH
  } riscv_imm_sel_e;

  // One decoded instruction as it travels toward execute.
  typedef struct packed {
    logic [3:0]  ctrl;
    logic        src_b_imm;
    logic [31:0] imm;
    logic        illegal;
  } riscv_alu_entry_t;

  localparam riscv_alu_entry_t RISCV_ENTRY_RESET = '{
    ctrl:      RISCV_ALU_ADD_OP,
    src_b_imm: 1'b0,
    imm:       32'h0000_0000,
    illegal:   1'b0
  };

  // Map funct3 (plus the funct7[5] alternate bit) to an ALU op.
  function automatic logic [3:0] riscv_f3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = RISCV_ALU_ADD_OP;
    case (f3)
      3'b000:  op = alt ? RISCV_ALU_SUB_OP : RISCV_ALU_ADD_OP;
      3'b001:  op = RISCV_ALU_SL_OP;
      3'b010:  op = RISCV_ALU_SLT_OP;
      3'b011:  op = RISCV_ALU_SLTU_OP;
      3'b100:  op = RISCV_ALU_XOR_OP;
      3'b101:  op = alt ? RISCV_ALU_SRA_OP : RISCV_ALU_SR_OP;
      3'b110:  op = RISCV_ALU_OR_OP;
      default: op = RISCV_ALU_AND_OP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_cu_alu_ctrl_imm_gen.sv
// Immediate generator: rebuilds the sign-extended immediate of an RV32I
// instruction word for the selected format. Purely combinational.
module riscv_cu_imm_gen
  import riscv_cu_alu_ctrl_pkg::*;
(
  input  logic [31:0]    instr_i,
  input  riscv_imm_sel_e sel_i,
  output logic [31:0]    imm_o
);

  // Reassemble the scattered immediate fields; everything sign-extends from bit 31.
  always_comb begin
    imm_o = 32'h0000_0000;
    case (sel_i)
      RISCV_IMM_I:  imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      RISCV_IMM_S:  imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      RISCV_IMM_B:  imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
      RISCV_IMM_U:  imm_o = {instr_i[31:12], 12'h000};
      RISCV_IMM_J:  imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
      RISCV_IMM_SH: imm_o = {27'h0, instr_i[24:20]};
      default:      imm_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/riscv_cu_alu_ctrl.sv
// Decode-stage ALU control producer: decodes an RV32I word into ALU op,
// operand-B select and immediate, and presents it through a two-entry
// valid/ready skid buffer so execute backpressure never loses an entry.
// Define RISCV_ALU_CTRL_ILLEGAL_EN to flag illegal encodings on oillegal.
module riscv_cu_alu_ctrl
  import riscv_cu_alu_ctrl_pkg::*;
#(
  parameter int MP_DATA_WIDTH = 32
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     ivalid,
  output logic                     oready,
  input  logic [31:0]              iinstr,
  output logic                     ovalid,
  input  logic                     iready,
  output logic [3:0]               octrl,
  output logic                     osrc_b_imm,
  output logic [MP_DATA_WIDTH-1:0] oimm,
  output logic                     oillegal
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  riscv_imm_sel_e   imm_sel;
  logic [31:0]      imm_raw;
  riscv_alu_entry_t dec;

  riscv_alu_entry_t main_q, main_d;
  riscv_alu_entry_t skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;
  logic             main_held;

`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
  logic [6:0] f7;
  logic       bad;
  assign f7 = iinstr[31:25];
`endif

  assign opcode = iinstr[6:0];
  assign f3     = iinstr[14:12];

  riscv_cu_imm_gen u_imm_gen (
    .instr_i (iinstr),
    .sel_i   (imm_sel),
    .imm_o   (imm_raw)
  );

  // Decode the incoming word into op, operand-B source and immediate format.
  always_comb begin
    dec.ctrl      = RISCV_ALU_ADD_OP;
    dec.src_b_imm = 1'b0;
    dec.illegal   = 1'b0;
    imm_sel       = RISCV_IMM_NONE;
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
    bad           = 1'b0;
`endif
    case (opcode)
      RISCV_OPC_OP: begin
        dec.ctrl = riscv_f3_op(f3, iinstr[30]);
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
        bad = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
`endif
      end
      RISCV_OPC_OP_IMM: begin
        dec.src_b_imm = 1'b1;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec.ctrl = riscv_f3_op(f3, iinstr[30]);
          imm_sel  = RISCV_IMM_SH;
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
          bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
`endif
        end else begin
          dec.ctrl = riscv_f3_op(f3, 1'b0);
          imm_sel  = RISCV_IMM_I;
        end
      end
      RISCV_OPC_LOAD: begin
        dec.src_b_imm = 1'b1;
        imm_sel       = RISCV_IMM_I;
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`endif
      end
      RISCV_OPC_JALR: begin
        dec.src_b_imm = 1'b1;
        imm_sel       = RISCV_IMM_I;
      end
      RISCV_OPC_STORE: begin
        dec.src_b_imm = 1'b1;
        imm_sel       = RISCV_IMM_S;
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
        bad = (f3 >= 3'b011);
`endif
      end
      RISCV_OPC_BRANCH: begin
        imm_sel = RISCV_IMM_B;
        case (f3[2:1])
          2'b10:   dec.ctrl = RISCV_ALU_SLT_OP;
          2'b11:   dec.ctrl = RISCV_ALU_SLTU_OP;
          default: dec.ctrl = RISCV_ALU_SUB_OP;
        endcase
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
        bad = (f3[2:1] == 2'b01);
`endif
      end
      RISCV_OPC_LUI, RISCV_OPC_AUIPC: begin
        dec.src_b_imm = 1'b1;
        imm_sel       = RISCV_IMM_U;
      end
      RISCV_OPC_JAL: begin
        dec.src_b_imm = 1'b1;
        imm_sel       = RISCV_IMM_J;
      end
      default: begin
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
        bad = 1'b1;
`endif
      end
    endcase
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
    if (bad) begin
      dec.ctrl      = RISCV_ALU_ADD_OP;
      dec.src_b_imm = 1'b0;
      dec.illegal   = 1'b1;
      imm_sel       = RISCV_IMM_NONE;
    end
`endif
    dec.imm = imm_raw;
  end

  // A full skid entry is the only thing that stops us accepting, so oready
  // comes straight from a flop and never depends on iready.
  assign accept    = ivalid && !skid_valid_q;
  assign main_held = main_valid_q && !iready;

  // Skid-buffer steering: park in skid while main is held, refill main from
  // skid first when it drains, otherwise load main directly.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (main_held) begin
      if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = dec;
      main_valid_d = 1'b1;
    end else begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight entries immediately.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      main_q       <= RISCV_ENTRY_RESET;
      skid_q       <= RISCV_ENTRY_RESET;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign oready     = !skid_valid_q;
  assign ovalid     = main_valid_q;
  assign octrl      = main_q.ctrl;
  assign osrc_b_imm = main_q.src_b_imm;
  assign oimm       = main_q.imm;
  assign oillegal   = main_q.illegal;

endmodule

// File: tb/tb_riscv_cu_alu_ctrl.sv
// Testbench for riscv_cu_alu_ctrl: directed scenarios plus a randomized
// stream whose expectations come from an instruction encoder model.
module tb_riscv_cu_alu_ctrl;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011;
  localparam logic [3:0] XOR_ = 4'b0100, SLT = 4'b0101, SLTU = 4'b1001;
  localparam logic [3:0] SL = 4'b0110, SR = 4'b0111, SRA = 4'b1010;
`ifdef RISCV_ALU_CTRL_ILLEGAL_EN
  localparam logic ILLEGAL_EN = 1'b1;
`else
  localparam logic ILLEGAL_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  ctrl;
    logic        src;
    logic [31:0] imm;
    logic        ill;
    logic        chkImm;
  } exp_t;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b1;
  logic        ivalid = 1'b0;
  logic        iready = 1'b0;
  logic [31:0] iinstr = 32'h0;
  logic        oready, ovalid, osrc_b_imm, oillegal;
  logic [3:0]  octrl;
  logic [31:0] oimm;

  int testsRun = 0;
  int testsFailed = 0;
  logic [3:0] opTable [8];
  exp_t sb [$];

  riscv_cu_alu_ctrl #(.MP_DATA_WIDTH(32)) dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .ivalid     (ivalid),
    .oready     (oready),
    .iinstr     (iinstr),
    .ovalid     (ovalid),
    .iready     (iready),
    .octrl      (octrl),
    .osrc_b_imm (osrc_b_imm),
    .oimm       (oimm),
    .oillegal   (oillegal)
  );

  always #5 iclk = ~iclk;

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction
  function automatic logic [31:0] encI(input logic [6:0] opc, input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd3, opc};
  endfunction
  function automatic logic [31:0] encS(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] encB(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] encJ(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
  endfunction

  // Pick a random instruction from its fields and derive what decode must give.
  task automatic gen(output logic [31:0] instr, output exp_t e);
    int kind, v;
    logic [31:0] vv;
    logic [2:0] f3;
    logic alt;
    logic [4:0] sh;
    logic [6:0] opc;
    int unsigned aluF3 [6] = '{0, 2, 3, 4, 6, 7};
    int unsigned ldF3 [5] = '{0, 1, 2, 4, 5};
    int unsigned brF3 [6] = '{0, 1, 4, 5, 6, 7};
    e = '{ctrl: ADD, src: 1'b1, imm: 32'h0, ill: 1'b0, chkImm: 1'b1};
    kind = $urandom_range(0, 10);
    case (kind)
      0: begin
        f3 = 3'($urandom_range(0, 7));
        alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
        instr = encR(alt ? 7'h20 : 7'h00, f3);
        e.ctrl = alt ? ((f3 == 3'd0) ? SUB : SRA) : opTable[f3];
        e.src = 1'b0;
        e.chkImm = 1'b0;
      end
      1: begin
        f3 = 3'(aluF3[$urandom_range(0, 5)]);
        v = int'($urandom_range(0, 4095)) - 2048; vv = v;
        instr = encI(7'h13, f3, vv[11:0]);
        e.ctrl = opTable[f3]; e.imm = vv;
      end
      2: begin
        f3 = $urandom_range(0, 1) ? 3'd5 : 3'd1;
        alt = (f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
        sh = 5'($urandom_range(0, 31));
        instr = {alt ? 7'h20 : 7'h00, sh, 5'd1, f3, 5'd3, 7'h13};
        e.ctrl = (f3 == 3'd1) ? SL : (alt ? SRA : SR);
        e.imm = {27'h0, sh};
      end
      3, 4: begin
        f3 = (kind == 3) ? 3'(ldF3[$urandom_range(0, 4)]) : 3'd0;
        v = int'($urandom_range(0, 4095)) - 2048; vv = v;
        instr = encI((kind == 3) ? 7'h03 : 7'h67, f3, vv[11:0]);
        e.imm = vv;
      end
      5: begin
        f3 = 3'($urandom_range(0, 2));
        v = int'($urandom_range(0, 4095)) - 2048; vv = v;
        instr = encS(f3, vv[11:0]);
        e.imm = vv;
      end
      6: begin
        f3 = 3'(brF3[$urandom_range(0, 5)]);
        v = 2 * int'($urandom_range(0, 4095)) - 4096; vv = v;
        instr = encB(f3, vv[12:0]);
        e.ctrl = (f3 < 3'd2) ? SUB : ((f3 < 3'd6) ? SLT : SLTU);
        e.src = 1'b0; e.imm = vv;
      end
      7, 8: begin
        vv = $urandom;
        instr = {vv[19:0], 5'd3, (kind == 7) ? 7'h37 : 7'h17};
        e.imm = {vv[19:0], 12'h000};
      end
      9: begin
        v = 2 * int'($urandom_range(0, (1 << 20) - 1)) - (1 << 20); vv = v;
        instr = encJ(vv[20:0]);
        e.imm = vv;
      end
      default: begin
        opc = 7'h7F;
        for (int k = 0; k < 50; k++) begin
          opc = 7'($urandom_range(0, 127));
          if (!(opc inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F})) break;
          opc = 7'h7F;
        end
        vv = $urandom;
        instr = {vv[31:7], opc};
        e.src = 1'b0; e.ill = ILLEGAL_EN;
      end
    endcase
  endtask

  task automatic test_reset();
    ivalid = 1'b0; iready = 1'b0; iinstr = 32'h0;
    #1 irst_n = 1'b0;
    #3;
    testsRun++; if (ovalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovalid: got %b want 0", ovalid); end
    testsRun++; if (octrl !== ADD) begin testsFailed++; $display("[TB] FAIL reset_octrl: got %b want 0000", octrl); end
    testsRun++; if ({osrc_b_imm, oillegal, oimm} !== 34'h0) begin testsFailed++; $display("[TB] FAIL reset_payload: got src=%b ill=%b imm=%h want zeros", osrc_b_imm, oillegal, oimm); end
    repeat (2) @(posedge iclk);
    #1 irst_n = 1'b1;
    @(posedge iclk); #1;
    testsRun++; if (oready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_oready: got %b want 1", oready); end
    testsRun++; if (ovalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_idle: got %b want 0", ovalid); end
  endtask

  task automatic test_alu_ops();
    iready = 1'b1;
    ivalid = 1'b1; iinstr = 32'h002081B3;
    @(posedge iclk); #1;
    iinstr = 32'h402081B3;
    testsRun++; if ({ovalid, octrl, osrc_b_imm} !== {1'b1, ADD, 1'b0}) begin testsFailed++; $display("[TB] FAIL add: got v=%b ctrl=%b src=%b want 1 0000 0", ovalid, octrl, osrc_b_imm); end
    @(posedge iclk); #1;
    iinstr = 32'h4030D093;
    testsRun++; if ({ovalid, octrl} !== {1'b1, SUB}) begin testsFailed++; $display("[TB] FAIL sub: got v=%b ctrl=%b want 1 0001", ovalid, octrl); end
    @(posedge iclk); #1;
    iinstr = encB(3'b100, 13'd8);
    testsRun++; if ({ovalid, octrl, osrc_b_imm, oimm} !== {1'b1, SRA, 1'b1, 32'd3}) begin testsFailed++; $display("[TB] FAIL srai: got v=%b ctrl=%b src=%b imm=%h want 1 1010 1 00000003", ovalid, octrl, osrc_b_imm, oimm); end
    @(posedge iclk); #1;
    iinstr = encB(3'b110, 13'd16);
    testsRun++; if ({octrl, osrc_b_imm, oimm} !== {SLT, 1'b0, 32'd8}) begin testsFailed++; $display("[TB] FAIL blt: got ctrl=%b src=%b imm=%h want 0101 0 00000008", octrl, osrc_b_imm, oimm); end
    @(posedge iclk); #1;
    iinstr = encB(3'b000, 13'h1FFC);
    testsRun++; if ({octrl, oimm} !== {SLTU, 32'd16}) begin testsFailed++; $display("[TB] FAIL bltu: got ctrl=%b imm=%h want 1001 00000010", octrl, oimm); end
    @(posedge iclk); #1;
    ivalid = 1'b0;
    testsRun++; if ({ovalid, octrl, oimm} !== {1'b1, SUB, 32'hFFFFFFFC}) begin testsFailed++; $display("[TB] FAIL beq: got v=%b ctrl=%b imm=%h want 1 0001 fffffffc", ovalid, octrl, oimm); end
    @(posedge iclk); #1;
    testsRun++; if (ovalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL ops_drain: got %b want 0", ovalid); end
  endtask

  task automatic test_backpressure();
    iready = 1'b0;
    ivalid = 1'b1; iinstr = encI(7'h13, 3'b000, 12'd5);
    @(posedge iclk); #1;
    testsRun++; if ({ovalid, oready, octrl, oimm} !== {1'b1, 1'b1, ADD, 32'd5}) begin testsFailed++; $display("[TB] FAIL bp_first: got v=%b rdy=%b ctrl=%b imm=%h want 1 1 0000 00000005", ovalid, oready, octrl, oimm); end
    iinstr = encI(7'h13, 3'b110, 12'd9);
    @(posedge iclk); #1;
    ivalid = 1'b0;
    testsRun++; if ({ovalid, oready, octrl, oimm} !== {1'b1, 1'b0, ADD, 32'd5}) begin testsFailed++; $display("[TB] FAIL bp_skid_full: got v=%b rdy=%b ctrl=%b imm=%h want 1 0 0000 00000005", ovalid, oready, octrl, oimm); end
    @(posedge iclk); #1;
    testsRun++; if ({ovalid, oready, octrl, oimm} !== {1'b1, 1'b0, ADD, 32'd5}) begin testsFailed++; $display("[TB] FAIL bp_hold: got v=%b rdy=%b ctrl=%b imm=%h want 1 0 0000 00000005", ovalid, oready, octrl, oimm); end
    iready = 1'b1;
    @(posedge iclk); #1;
    testsRun++; if ({ovalid, oready, octrl, oimm} !== {1'b1, 1'b1, OR_, 32'd9}) begin testsFailed++; $display("[TB] FAIL bp_second: got v=%b rdy=%b ctrl=%b imm=%h want 1 1 0011 00000009", ovalid, oready, octrl, oimm); end
    @(posedge iclk); #1;
    testsRun++; if (ovalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_drain: got %b want 0", ovalid); end
  endtask

  task automatic test_reset_mid_stall();
    iready = 1'b0;
    ivalid = 1'b1; iinstr = encI(7'h13, 3'b100, 12'hFFF);
    @(posedge iclk); #1;
    iinstr = encR(7'h20, 3'b000);
    @(posedge iclk); #1;
    ivalid = 1'b0;
    testsRun++; if ({oready, octrl, oimm} !== {1'b0, XOR_, 32'hFFFFFFFF}) begin testsFailed++; $display("[TB] FAIL rst_setup: got rdy=%b ctrl=%b imm=%h want 0 0100 ffffffff", oready, octrl, oimm); end
    #2 irst_n = 1'b0;
    #1;
    testsRun++; if ({ovalid, octrl, oimm, osrc_b_imm} !== {1'b0, ADD, 32'h0, 1'b0}) begin testsFailed++; $display("[TB] FAIL rst_async: got v=%b ctrl=%b imm=%h src=%b want 0 0000 0 0", ovalid, octrl, oimm, osrc_b_imm); end
    @(posedge iclk); #1;
    irst_n = 1'b1; iready = 1'b1;
    @(posedge iclk); #1;
    testsRun++; if ({oready, ovalid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL rst_release: got rdy=%b v=%b want 1 0", oready, ovalid); end
    @(posedge iclk); #1;
    testsRun++; if (ovalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_discard: got %b want 0", ovalid); end
  endtask

  task automatic test_illegal();
    iready = 1'b1;
    ivalid = 1'b1; iinstr = 32'hFFF0007F;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    testsRun++; if ({ovalid, oillegal} !== {1'b1, ILLEGAL_EN}) begin testsFailed++; $display("[TB] FAIL illegal_flag: got v=%b ill=%b want 1 %b", ovalid, oillegal, ILLEGAL_EN); end
    testsRun++; if ({octrl, osrc_b_imm, oimm} !== {ADD, 1'b0, 32'h0}) begin testsFailed++; $display("[TB] FAIL illegal_payload: got ctrl=%b src=%b imm=%h want 0000 0 0", octrl, osrc_b_imm, oimm); end
    @(posedge iclk); #1;
  endtask

  task automatic test_random();
    logic [31:0] nextInstr;
    exp_t nextExp, e;
    logic pending, heldLast;
    logic [37:0] heldPayload;
    pending = 1'b0; heldLast = 1'b0; heldPayload = '0; nextInstr = 32'h0;
    nextExp = '{ctrl: ADD, src: 1'b0, imm: 32'h0, ill: 1'b0, chkImm: 1'b0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      testsRun++; if (ovalid !== 1'(sb.size() > 0)) begin testsFailed++; $display("[TB] FAIL rnd_ovalid cyc %0d: got %b want %b", cyc, ovalid, sb.size() > 0); end
      testsRun++; if (oready !== 1'(sb.size() < 2)) begin testsFailed++; $display("[TB] FAIL rnd_oready cyc %0d: got %b want %b", cyc, oready, sb.size() < 2); end
      if (heldLast && ovalid) begin
        testsRun++; if ({octrl, osrc_b_imm, oimm, oillegal} !== heldPayload) begin testsFailed++; $display("[TB] FAIL rnd_stable cyc %0d: got %h want %h", cyc, {octrl, osrc_b_imm, oimm, oillegal}, heldPayload); end
      end
      if (!pending && ($urandom_range(0, 3) != 0)) begin gen(nextInstr, nextExp); pending = 1'b1; end
      ivalid = pending; iinstr = nextInstr; iready = ($urandom_range(0, 2) != 0);
      if (ovalid && iready && sb.size() > 0) begin
        e = sb.pop_front();
        testsRun++; if ({octrl, osrc_b_imm, oillegal} !== {e.ctrl, e.src, e.ill}) begin testsFailed++; $display("[TB] FAIL rnd_ctrl cyc %0d: got ctrl=%b src=%b ill=%b want %b %b %b", cyc, octrl, osrc_b_imm, oillegal, e.ctrl, e.src, e.ill); end
        if (e.chkImm) begin
          testsRun++; if (oimm !== e.imm) begin testsFailed++; $display("[TB] FAIL rnd_imm cyc %0d: got %h want %h", cyc, oimm, e.imm); end
        end
      end
      if (ivalid && oready) begin sb.push_back(nextExp); pending = 1'b0; end
      heldLast = ovalid && !iready;
      heldPayload = {octrl, osrc_b_imm, oimm, oillegal};
      @(posedge iclk); #1;
    end
    ivalid = 1'b0; iready = 1'b1;
    for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
      if (ovalid) begin
        e = sb.pop_front();
        testsRun++; if ({octrl, osrc_b_imm, oillegal} !== {e.ctrl, e.src, e.ill}) begin testsFailed++; $display("[TB] FAIL drain_ctrl: got ctrl=%b src=%b ill=%b want %b %b %b", octrl, osrc_b_imm, oillegal, e.ctrl, e.src, e.ill); end
        if (e.chkImm) begin
          testsRun++; if (oimm !== e.imm) begin testsFailed++; $display("[TB] FAIL drain_imm: got %h want %h", oimm, e.imm); end
        end
      end
      @(posedge iclk); #1;
    end
    testsRun++; if (sb.size() != 0 || ovalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_timeout: %0d entries left, ovalid=%b, want 0 and 0", sb.size(), ovalid); end
  endtask

  initial begin
    opTable = '{ADD, SL, SLT, SLTU, XOR_, SR, OR_, AND_};
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_reset_mid_stall();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
